// File: rtl/log_event_arbiter.sv
// log_event_arbiter: multi-source front end for the BRAM event logger.
// Buffers one event per requester, issues them round-robin to the logger's
// single trigger/data port tagged with the source index, sequences logger
// clears and discards events while the logger is hard-full.
// Optional feature macro: LOG_ARB_DROP_CNT_EN enables the per-source
// saturating drop counters; without it DropCnt_DO is tied to zero.
module log_event_arbiter #(
  parameter int NUM_SRC       = 4,
  parameter int SRC_DATA_BITW = 24,
  parameter int DROP_CNT_BITW = 16
) (
  input  logic                              Clk_CI,
  input  logic                              Rst_RBI,
  input  logic [NUM_SRC-1:0]                SrcValid_SI,
  input  logic [NUM_SRC*SRC_DATA_BITW-1:0]  SrcData_DI,
  output logic [NUM_SRC-1:0]                SrcReady_SO,
  input  logic                              CmdEn_SI,
  input  logic                              CmdClear_SI,
  output logic                              Busy_SO,
  input  logic                              LogReady_SI,
  input  logic                              LogFull_SI,
  output logic                              LogEn_SO,
  output logic                              LogTrigger_SO,
  output logic [31:0]                       LogData_DO,
  output logic                              Clear_SO,
  output logic [NUM_SRC*DROP_CNT_BITW-1:0]  DropCnt_DO
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    CLEAR_REQ  = 2'd2,
    CLEAR_WAIT = 2'd3
  } state_t;

  state_t                   state_reg, state_next;
  logic [NUM_SRC-1:0]       pending_reg;
  logic [SRC_DATA_BITW-1:0] hold_data_reg [NUM_SRC];
  logic [IDX_W-1:0]         last_grant_reg;

  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_found;
  int                       cand_idx;
  logic [IDX_W-1:0]         cand_sel;
  logic                     issue;
  logic                     discard;
  logic [NUM_SRC-1:0]       capture;
  logic [NUM_SRC-1:0]       retire;
  logic [31:0]              log_data;

  // A source is ready whenever its single holding slot is empty.
  assign SrcReady_SO = ~pending_reg;
  assign capture     = SrcValid_SI & ~pending_reg;

  // Round-robin search starting just after the last source served.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = 0;
    cand_sel    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand_idx = (int'(last_grant_reg) + 1 + k) % NUM_SRC;
      cand_sel = cand_idx[IDX_W-1:0];
      if (!grant_found && pending_reg[cand_sel]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sel;
      end
    end
  end

  // Issue and discard are only possible while running; the entry leaves
  // either way, the difference is whether the logger sees it.
  assign issue   = (state_reg == RUN) && LogReady_SI && grant_found;
  assign discard = (state_reg == RUN) && !LogReady_SI && LogFull_SI && grant_found;

  // One-hot mask of the entry leaving its slot this cycle.
  always_comb begin
    retire = '0;
    if (issue || discard) begin
      retire[grant_idx] = 1'b1;
    end
  end

  // Logger word: source tag in the top byte, payload at the bottom, zero
  // whenever nothing is being triggered.
  always_comb begin
    log_data = '0;
    if (issue) begin
      log_data[31:24]              = 8'(grant_idx);
      log_data[SRC_DATA_BITW-1:0]  = hold_data_reg[grant_idx];
    end
  end

  assign LogTrigger_SO = issue;
  assign LogData_DO    = log_data;

  // Pending bits: capture and retire never hit the same slot in one cycle
  // because capture needs an empty slot and retire a full one.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= (pending_reg | capture) & ~retire;
    end
  end

  // Payload holding registers; contents only matter while pending.
  always_ff @(posedge Clk_CI) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (capture[i]) begin
        hold_data_reg[i] <= SrcData_DI[i*SRC_DATA_BITW +: SRC_DATA_BITW];
      end
    end
  end

  // Round-robin pointer moves only when an entry actually leaves.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      last_grant_reg <= IDX_W'(NUM_SRC - 1);
    end else if (issue || discard) begin
      last_grant_reg <= grant_idx;
    end
  end

  // Control state register.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and state-decoded outputs; clear wins over enable changes.
  always_comb begin
    state_next = state_reg;
    LogEn_SO   = 1'b0;
    Clear_SO   = 1'b0;
    Busy_SO    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (CmdClear_SI) begin
          state_next = CLEAR_REQ;
        end else if (CmdEn_SI) begin
          state_next = RUN;
        end
      end
      RUN: begin
        LogEn_SO = 1'b1;
        if (CmdClear_SI) begin
          state_next = CLEAR_REQ;
        end else if (!CmdEn_SI) begin
          state_next = IDLE;
        end
      end
      CLEAR_REQ: begin
        Clear_SO   = 1'b1;
        Busy_SO    = 1'b1;
        state_next = CLEAR_WAIT;
      end
      CLEAR_WAIT: begin
        Busy_SO = 1'b1;
        if (LogReady_SI) begin
          state_next = CmdEn_SI ? RUN : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef LOG_ARB_DROP_CNT_EN
  genvar gi;
  for (gi = 0; gi < NUM_SRC; gi++) begin : g_drop
    logic [DROP_CNT_BITW-1:0] drop_cnt_reg;

    // Saturating count of events thrown away while the logger was full;
    // wiped together with the logger.
    always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
        drop_cnt_reg <= '0;
      end else if (state_reg == CLEAR_REQ) begin
        drop_cnt_reg <= '0;
      end else if (discard && retire[gi] && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + DROP_CNT_BITW'(1);
      end
    end

    assign DropCnt_DO[gi*DROP_CNT_BITW +: DROP_CNT_BITW] = drop_cnt_reg;
  end
`else
  assign DropCnt_DO = '0;
`endif

endmodule
